// File: rtl/hilo_acc.sv
// HI/LO register pair with an optional two-stage 2W-bit accumulate/subtract pipeline.
// Define HILO_ACC_EN to build the accumulate pipeline; without it modes 100/101 are NOPs.
module hilo_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   wmode,
  input  logic [W-1:0] whidata,
  input  logic [W-1:0] wlodata,
  output logic [W-1:0] rhidata,
  output logic [W-1:0] rlodata,
  output logic         rhi_valid
);

  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic         w_wr_hi;
  logic         w_wr_lo;

  assign w_wr_hi = (wmode == 3'b001) || (wmode == 3'b011);
  assign w_wr_lo = (wmode == 3'b010) || (wmode == 3'b011);

  assign rhidata = r_hi;
  assign rlodata = r_lo;

`ifdef HILO_ACC_EN
  logic           r_s2_valid;
  logic [W-1:0]   r_s2_b;
  logic           r_s2_c;
  logic           w_acc;
  logic           w_sub;
  logic [2*W-1:0] w_b;
  logic [W:0]     w_losum;

  assign w_acc   = (wmode == 3'b100) || (wmode == 3'b101);
  assign w_sub   = wmode[0];
  assign w_b     = w_sub ? ~{whidata, wlodata} : {whidata, wlodata};
  assign w_losum = {1'b0, r_lo} + {1'b0, w_b[W-1:0]} + {{W{1'b0}}, w_sub};

  // A later HI write in program order overrides any pending high-half update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_b     <= '0;
      r_s2_c     <= 1'b0;
    end else begin
      if (w_wr_hi)
        r_hi <= whidata;
      else if (r_s2_valid)
        r_hi <= r_hi + r_s2_b + {{(W-1){1'b0}}, r_s2_c};
      if (w_wr_lo)
        r_lo <= wlodata;
      else if (w_acc)
        r_lo <= w_losum[W-1:0];
      r_s2_valid <= w_acc;
      if (w_acc) begin
        r_s2_b <= w_b[2*W-1:W];
        r_s2_c <= w_losum[W];
      end
    end
  end

  assign rhi_valid = !r_s2_valid;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_wr_hi)
        r_hi <= whidata;
      if (w_wr_lo)
        r_lo <= wlodata;
    end
  end

  assign rhi_valid = 1'b1;
`endif

endmodule

// File: doc/hilo_acc.md
# hilo_acc

Parametrised HI/LO register pair for the MIPS execute/writeback path, successor to the plain HI/LO register. It adds a 2W-bit accumulate/subtract pipeline for MADD/MSUB-class instructions, with a split-carry low/high update. It also provides a validity flag for the HI read port. It sits after the multiplier: the multiplier (or a MTHI/MTLO path) presents a 2W-bit operand, and readers (MFHI/MFLO) sample `rhidata`/`rlodata`.

## Interface
- `W`, default 32: width of each of HI and LO.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wmode`  in  3  request opcode, one per cycle:
  - 000: NOP
  - 001: WHI
  - 010: WLO
  - 011: WBOTH
  - 100: ADD
  - 101: SUB
  - 110, 111: NOP
- `whidata`  in  W  write data for HI; upper half of the accumulate operand.
- `wlodata`  in  W  write data for LO; lower half of the accumulate operand.
- `rhidata`  out  W  current HI register.
- `rlodata`  out  W  current LO register.
- `rhi_valid`  out  1  high when `rhidata` includes all accepted requests.

## Operation
- State:
  - `hi`, `lo` registers.
  - Stage-2 slot: `s2_valid`, `s2_b` (W bits), `s2_c` (1 bit).
- Direct writes (001/010/011) load the selected register(s) from `whidata`/`wlodata` at the edge.
- Accumulate (100/101) on the 2W value {hi,lo}:
  - Let `P` = {whidata,wlodata}.
  - `sub` = wmode[0]; `B` = sub ? ~P : P; carry-in = sub.
  - Stage 1, in the request cycle: `lo <= lo + B[W-1:0] + sub` (low W bits). The carry-out goes to `s2_c`, `B[2W-1:W]` goes to `s2_b`, and `s2_valid <= 1`.
  - Stage 2, the following cycle: `hi <= hi + s2_b + s2_c` (modulo 2^W), then `s2_valid <= 0` unless a new ADD/SUB refills the slot.
- Arithmetic is modulo 2^(2W), so signed and unsigned MADD/MSUB are the same operation; signedness is the multiplier's concern.
- Requests are accepted every cycle. There is no backpressure, and throughput is 1 per cycle.
- Back-to-back ADD/SUB: the stage-2 update of the older request and the stage-1 update of the newer request happen in the same cycle. The newer request's stage 2 uses the freshly written `hi`.
- WHI or WBOTH in a cycle with `s2_valid` = 1: the new write wins and the pending high update is discarded (program order: later overwrite).
- WLO or NOP with `s2_valid` = 1: the pending high update completes normally.
- `rhi_valid` = !`s2_valid`. `rlodata` is always final.
- Reset: `hi` = 0, `lo` = 0, `s2_valid` = 0, `s2_b` = 0, `s2_c` = 0, `rhi_valid` = 1. An in-flight accumulate is dropped.

## Timing
- Direct write at edge t: visible on `rhidata`/`rlodata` after edge t.
- ADD/SUB at cycle t:
  - `rlodata` is final after edge t.
  - `rhidata` is final after edge t+1.
  - `rhi_valid` is low for cycle t+1 only, unless refilled.
- N consecutive ADD/SUB starting at cycle t: `rhi_valid` is low for cycles t+1 … t+N and high at t+N+1.
- All outputs are registers or a single inverter; there is no combinational path from inputs to outputs.

## Configuration
- `HILO_ACC_EN` defined:
  - Accumulate pipeline is present.
  - Modes 100/101 behave as above.
- `HILO_ACC_EN` undefined:
  - Modes 100/101 are NOPs.
  - No stage-2 state is built.
  - `rhi_valid` is tied to 1.
  - The block reduces to W-wide HI/LO registers with independent write enables.

## Test plan
- Reset, then WBOTH with `whidata`=0x12345678 and `wlodata`=0x9ABCDEF0 → next cycle `rhidata`=0x12345678, `rlodata`=0x9ABCDEF0, `rhi_valid`=1.
- Start from {0x00000000, 0xFFFFFFFF}, ADD P=0x0000_0000_0000_0001:
  - after edge t: `rlodata`=0, `rhidata`=0, `rhi_valid`=0;
  - after edge t+1: `rhidata`=1, `rhi_valid`=1.
- Start from {0x00000001, 0x00000000}, SUB P=1 → {0x00000000, 0xFFFFFFFF} after two edges. Then SUB P=0xFFFFFFFF_FFFFFFFF → {0x00000001, 0x00000000}.
- Start from {0,0}, ADD 0xFFFFFFFF for 3 back-to-back cycles → final {0x00000002, 0xFFFFFFFD}, with `rhi_valid` low for exactly 3 cycles.
- ADD P=0x00000005_00000000, then WHI 0xAAAA0000 in the next cycle → `rhidata`=0xAAAA0000; the pending +5 is discarded. ADD followed by WLO 7 instead → `rhidata` gets +5 and `rlodata`=7.
- `rst` asserted in the cycle after an ADD → all state 0 and `rhi_valid`=1 next cycle. With `HILO_ACC_EN` undefined, ADD leaves {hi,lo} unchanged.
